// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard controller: FSM state encoding and the
// operand forwarding select codes.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      FLUSH    = 2'd2,
      MEM_WAIT = 2'd3
   } hz_state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_MA = 2'b01;
   localparam logic [1:0] FWD_WB = 2'b10;

endpackage

// File: rtl/fwd_sel_logic.sv
// Forwarding select for one EX source operand; the MA result wins over WB
// because it is the younger write to the same register.
module fwd_sel_logic
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs_ex,
   input  logic [REG_ADDR_W-1:0] rd_ma,
   input  logic [REG_ADDR_W-1:0] rd_wb,
   input  logic                  regwen_ma,
   input  logic                  regwen_wb,
   output logic [1:0]            fwd_sel
);

   always_comb begin
      fwd_sel = FWD_RF;
      if (regwen_ma && (rd_ma != '0) && (rd_ma == rs_ex)) begin
         fwd_sel = FWD_MA;
      end else if (regwen_wb && (rd_wb != '0) && (rd_wb == rs_ex)) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding, load-use stall,
// branch squash and data-memory freeze. Define HAZARD_PERF_CNT_EN for counters.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W        = 5,
   parameter int FLUSH_DEPTH       = 2,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic [REG_ADDR_W-1:0] rs1_ex,
   input  logic [REG_ADDR_W-1:0] rs2_ex,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic [REG_ADDR_W-1:0] rd_ma,
   input  logic [REG_ADDR_W-1:0] rd_wb,
   input  logic                  regwen_ex,
   input  logic                  regwen_ma,
   input  logic                  regwen_wb,
   input  logic                  memread_ex,
   input  logic                  pcsel_ex,
   input  logic                  dmem_req,
   input  logic                  dmem_ready,
   output logic [1:0]            fwd_sel_a,
   output logic [1:0]            fwd_sel_b,
   output logic                  stall_if,
   output logic                  stall_id,
   output logic                  bubble_ex,
   output logic                  flush_id,
   output logic                  stall_all,
   output logic [1:0]            state_o,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam int CNT_MAX = (FLUSH_DEPTH > LOAD_STALL_CYCLES) ? FLUSH_DEPTH : LOAD_STALL_CYCLES;
   localparam int SEQ_W   = $clog2(CNT_MAX + 1);
   localparam logic [SEQ_W-1:0] FLUSH_LOAD = SEQ_W'(FLUSH_DEPTH - 2);
   localparam logic [SEQ_W-1:0] STALL_LOAD = SEQ_W'(LOAD_STALL_CYCLES - 1);
   localparam logic [SEQ_W-1:0] SEQ_ONE    = SEQ_W'(1);

   hz_state_e        state, state_nxt;
   logic [SEQ_W-1:0] seq_cnt, seq_cnt_nxt;
   logic [1:0]       fwd_a_raw, fwd_b_raw;
   logic             load_use, mem_wait;

   fwd_sel_logic #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .rs_ex(rs1_ex), .rd_ma(rd_ma), .rd_wb(rd_wb),
      .regwen_ma(regwen_ma), .regwen_wb(regwen_wb), .fwd_sel(fwd_a_raw)
   );

   fwd_sel_logic #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .rs_ex(rs2_ex), .rd_ma(rd_ma), .rd_wb(rd_wb),
      .regwen_ma(regwen_ma), .regwen_wb(regwen_wb), .fwd_sel(fwd_b_raw)
   );

   assign fwd_sel_a = reset_n ? fwd_a_raw : FWD_RF;
   assign fwd_sel_b = reset_n ? fwd_b_raw : FWD_RF;
   assign state_o   = state;

   assign load_use = memread_ex & regwen_ex & (rd_ex != '0) &
                     ((rd_ex == rs1_id) | (rd_ex == rs2_id));
   assign mem_wait = dmem_req & ~dmem_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= RUN;
         seq_cnt <= '0;
      end else begin
         state   <= state_nxt;
         seq_cnt <= seq_cnt_nxt;
      end
   end

   // A taken branch outranks any stall because the ID instruction is wrong-path;
   // a memory wait outranks everything since nothing may advance.
   always_comb begin
      state_nxt   = state;
      seq_cnt_nxt = seq_cnt;
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      bubble_ex   = 1'b0;
      flush_id    = 1'b0;
      stall_all   = 1'b0;
      if (reset_n) begin
         if (state == MEM_WAIT) begin
            if (!dmem_ready) stall_all = 1'b1;
            else             state_nxt = RUN;
         end else if (mem_wait) begin
            stall_all = 1'b1;
            state_nxt = MEM_WAIT;
         end else if (pcsel_ex) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
            if (FLUSH_DEPTH > 2) begin
               state_nxt   = FLUSH;
               seq_cnt_nxt = FLUSH_LOAD;
            end else begin
               state_nxt = RUN;
            end
         end else begin
            case (state)
               RUN: begin
                  if (load_use) begin
                     stall_if  = 1'b1;
                     stall_id  = 1'b1;
                     bubble_ex = 1'b1;
                     if (LOAD_STALL_CYCLES > 1) begin
                        state_nxt   = LD_STALL;
                        seq_cnt_nxt = STALL_LOAD;
                     end
                  end
               end
               LD_STALL: begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  bubble_ex = 1'b1;
                  if (seq_cnt <= SEQ_ONE) state_nxt   = RUN;
                  else                    seq_cnt_nxt = seq_cnt - SEQ_ONE;
               end
               FLUSH: begin
                  flush_id = 1'b1;
                  if (seq_cnt <= SEQ_ONE) state_nxt   = RUN;
                  else                    seq_cnt_nxt = seq_cnt - SEQ_ONE;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // flush_id together with bubble_ex marks exactly the cycles that accept a branch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if | stall_all)  stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_id & bubble_ex)  flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: two instances (FLUSH_DEPTH=3/LOAD_STALL_CYCLES=1
// and FLUSH_DEPTH=2/LOAD_STALL_CYCLES=3) share one set of stimulus.
module tb_hazard_ctrl_unit;

   typedef struct {
      logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_ma, rd_wb;
      logic       wen_ex, wen_ma, wen_wb, memread, pcsel, dreq, drdy;
      logic [8:0] exp_out;
      logic [1:0] exp_state;
      string      name;
   } vec_t;

`ifdef HAZARD_PERF_CNT_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_ma, rd_wb;
   logic       regwen_ex, regwen_ma, regwen_wb, memread_ex, pcsel_ex, dmem_req, dmem_ready;

   logic [1:0]  fa_a, fb_a, st_a, fa_b, fb_b, st_b;
   logic        sif_a, sid_a, bub_a, fl_a, sa_a, sif_b, sid_b, bub_b, fl_b, sa_b;
   logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
   logic [8:0]  outs_a, outs_b;

   int errors = 0;
   int checks = 0;

   assign outs_a = {fa_a, fb_a, sif_a, sid_a, bub_a, fl_a, sa_a};
   assign outs_b = {fa_b, fb_b, sif_b, sid_b, bub_b, fl_b, sa_b};

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.REG_ADDR_W(5), .FLUSH_DEPTH(3), .LOAD_STALL_CYCLES(1), .CNT_W(32)) dut_a (
      .clk(clk), .reset_n(reset_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex),
      .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rd_ma(rd_ma), .rd_wb(rd_wb), .regwen_ex(regwen_ex),
      .regwen_ma(regwen_ma), .regwen_wb(regwen_wb), .memread_ex(memread_ex), .pcsel_ex(pcsel_ex),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .fwd_sel_a(fa_a), .fwd_sel_b(fb_a),
      .stall_if(sif_a), .stall_id(sid_a), .bubble_ex(bub_a), .flush_id(fl_a), .stall_all(sa_a),
      .state_o(st_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a)
   );

   hazard_ctrl_unit #(.REG_ADDR_W(5), .FLUSH_DEPTH(2), .LOAD_STALL_CYCLES(3), .CNT_W(32)) dut_b (
      .clk(clk), .reset_n(reset_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex),
      .rs2_ex(rs2_ex), .rd_ex(rd_ex), .rd_ma(rd_ma), .rd_wb(rd_wb), .regwen_ex(regwen_ex),
      .regwen_ma(regwen_ma), .regwen_wb(regwen_wb), .memread_ex(memread_ex), .pcsel_ex(pcsel_ex),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .fwd_sel_a(fa_b), .fwd_sel_b(fb_b),
      .stall_if(sif_b), .stall_id(sid_b), .bubble_ex(bub_b), .flush_id(fl_b), .stall_all(sa_b),
      .state_o(st_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0;
      rd_ex = '0; rd_ma = '0; rd_wb = '0;
      regwen_ex = 1'b0; regwen_ma = 1'b0; regwen_wb = 1'b0;
      memread_ex = 1'b0; pcsel_ex = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b1;
   endtask

   task automatic load_use_rs2();
      rd_ex = 5'd6; rs2_id = 5'd6; regwen_ex = 1'b1; memread_ex = 1'b1;
   endtask

   task automatic drive(input vec_t v);
      rs1_id = v.rs1_id; rs2_id = v.rs2_id; rs1_ex = v.rs1_ex; rs2_ex = v.rs2_ex;
      rd_ex = v.rd_ex; rd_ma = v.rd_ma; rd_wb = v.rd_wb;
      regwen_ex = v.wen_ex; regwen_ma = v.wen_ma; regwen_wb = v.wen_wb;
      memread_ex = v.memread; pcsel_ex = v.pcsel; dmem_req = v.dreq; dmem_ready = v.drdy;
   endtask

   task automatic settle();
      idle();
      for (int k = 0; k < 6 && (st_a != 2'd0 || st_b != 2'd0); k++) tick();
      chk("settle_states", {28'd0, st_a, st_b}, 32'd0);
   endtask

   vec_t        tbl[13];
   logic [31:0] s0, f0;

   initial begin
      //            rs1id  rs2id  rs1ex  rs2ex  rdex   rdma   rdwb  wex  wma  wwb  mrd  pcs  drq  drdy  exp_out       st
      tbl[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 9'b01_00_00000, 2'd0, "fwd_ma_prio"};
      tbl[1]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 9'b00_00_00000, 2'd0, "fwd_x0"};
      tbl[2]  = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd7, 5'd7, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 9'b00_10_00000, 2'd0, "fwd_wb"};
      tbl[3]  = '{5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 5'd4, 5'd3, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 9'b10_01_00000, 2'd0, "fwd_both"};
      tbl[4]  = '{5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 9'b00_00_11100, 2'd0, "lu_rs2"};
      tbl[5]  = '{5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 9'b00_00_00000, 2'd0, "lu_nowen"};
      tbl[6]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 9'b00_00_00000, 2'd0, "lu_x0"};
      tbl[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 9'b00_00_00110, 2'd2, "branch"};
      tbl[8]  = '{5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1, 9'b00_00_00110, 2'd2, "branch_lu"};
      tbl[9]  = '{5'd0, 5'd6, 5'd5, 5'd0, 5'd6, 5'd5, 5'd0, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0, 9'b01_00_00001, 2'd3, "mem_wait"};
      tbl[10] = '{5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1, 9'b00_00_11100, 2'd0, "mem_ready_lu"};
      tbl[11] = '{5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 9'b00_00_11100, 2'd0, "lu_rs1"};
      tbl[12] = '{5'd5, 5'd4, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 9'b00_00_00000, 2'd0, "lu_miss"};

      // Reset holds every control output low even with hazards on the inputs.
      reset_n = 1'b0;
      drive(tbl[9]);
      #2;
      chk("rst_outs_a", {23'd0, outs_a}, 32'd0);
      chk("rst_outs_b", {23'd0, outs_b}, 32'd0);
      idle();
      #10 reset_n = 1'b1;
      #1;
      chk("rst_state", {28'd0, st_a, st_b}, 32'd0);
      chk("rst_cnt_a", scnt_a | fcnt_a, 32'd0);

      foreach (tbl[i]) begin
         settle();
         drive(tbl[i]);
         #1 chk(tbl[i].name, {23'd0, outs_a}, {23'd0, tbl[i].exp_out});
         tick();
         chk({tbl[i].name, "_st"}, {30'd0, st_a}, {30'd0, tbl[i].exp_state});
      end

      // Load-use with one bubble, then WB forwarding on the retry.
      settle();
      s0 = scnt_a;
      load_use_rs2();
      #1 chk("lu1_c0", {23'd0, outs_a}, {23'd0, 9'b00_00_11100});
      tick();
      chk("lu1_c0_st", {30'd0, st_a}, 32'd0);
      idle(); rd_ma = 5'd6; regwen_ma = 1'b1; rs2_id = 5'd6;
      #1 chk("lu1_c1", {23'd0, outs_a}, 32'd0);
      tick();
      idle(); rs2_ex = 5'd6; rd_wb = 5'd6; regwen_wb = 1'b1;
      #1 chk("lu1_retry", {23'd0, outs_a}, {23'd0, 9'b00_10_00000});
      tick();
      chk("lu1_stall_cnt", scnt_a - s0, 32'(PERF));

      // Branch coincident with load-use, FLUSH_DEPTH=3.
      settle();
      s0 = scnt_a; f0 = fcnt_a;
      load_use_rs2(); pcsel_ex = 1'b1;
      #1 chk("br3_c0", {23'd0, outs_a}, {23'd0, 9'b00_00_00110});
      tick();
      chk("br3_c0_st", {30'd0, st_a}, 32'd2);
      idle();
      #1 chk("br3_c1", {23'd0, outs_a}, {23'd0, 9'b00_00_00010});
      tick();
      chk("br3_c1_st", {30'd0, st_a}, 32'd0);
      chk("br3_c2", {23'd0, outs_a}, 32'd0);
      chk("br3_flush_cnt", fcnt_a - f0, 32'(PERF));
      chk("br3_stall_cnt", scnt_a - s0, 32'd0);

      // Data-memory wait for three cycles, then the completion cycle.
      settle();
      s0 = scnt_a; f0 = fcnt_a;
      for (int c = 0; c < 3; c++) begin
         idle(); load_use_rs2(); dmem_req = 1'b1; dmem_ready = 1'b0;
         if (c == 0) pcsel_ex = 1'b1;
         #1 chk($sformatf("mw_c%0d", c), {23'd0, outs_a}, {23'd0, 9'b00_00_00001});
         tick();
         chk($sformatf("mw_c%0d_st", c), {30'd0, st_a}, 32'd3);
      end
      idle(); dmem_req = 1'b1;
      #1 chk("mw_ready", {23'd0, outs_a}, 32'd0);
      tick();
      chk("mw_ready_st", {30'd0, st_a}, 32'd0);
      chk("mw_stall_cnt", scnt_a - s0, 32'(PERF * 3));
      chk("mw_flush_cnt", fcnt_a - f0, 32'd0);

      // LOAD_STALL_CYCLES=3 and FLUSH_DEPTH=2 on the second instance.
      settle();
      s0 = scnt_b;
      load_use_rs2();
      #1 chk("lu3_c0", {23'd0, outs_b}, {23'd0, 9'b00_00_11100});
      tick();
      chk("lu3_c0_st", {30'd0, st_b}, 32'd1);
      idle();
      #1 chk("lu3_c1", {23'd0, outs_b}, {23'd0, 9'b00_00_11100});
      tick();
      chk("lu3_c1_st", {30'd0, st_b}, 32'd1);
      chk("lu3_c2", {23'd0, outs_b}, {23'd0, 9'b00_00_11100});
      tick();
      chk("lu3_c2_st", {30'd0, st_b}, 32'd0);
      chk("lu3_c3", {23'd0, outs_b}, 32'd0);
      chk("lu3_stall_cnt", scnt_b - s0, 32'(PERF * 3));

      settle();
      f0 = fcnt_b;
      pcsel_ex = 1'b1;
      #1 chk("br2_c0", {23'd0, outs_b}, {23'd0, 9'b00_00_00110});
      tick();
      chk("br2_c0_st", {30'd0, st_b}, 32'd0);
      chk("br2_flush_cnt", fcnt_b - f0, 32'(PERF));

      // Reset dropped in the middle of a long load-use stall.
      settle();
      load_use_rs2(); rs1_ex = 5'd5; rd_ma = 5'd5; regwen_ma = 1'b1;
      tick();
      chk("lu3r_st", {30'd0, st_b}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("lu3r_outs_b", {23'd0, outs_b}, 32'd0);
      chk("lu3r_outs_a", {23'd0, outs_a}, 32'd0);
      chk("lu3r_state", {28'd0, st_a, st_b}, 32'd0);
      idle();
      tick();
      reset_n = 1'b1;
      #1;
      chk("post_rst_state", {28'd0, st_a, st_b}, 32'd0);
      chk("post_rst_cnt_b", scnt_b | fcnt_b, 32'd0);
      chk("post_rst_cnt_a", scnt_a | fcnt_a, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised hazard controller for the 5-stage RV32I pipeline; supersedes the standalone forwarding unit. It produces the operand forwarding selects for EX and detects load-use hazards, inserting a stall and bubble. It squashes wrong-path instructions after a taken branch or jump resolves in EX, and freezes the pipeline while a data-memory access is outstanding. It sits beside the stage modules in the CPU top and drives their stall, flush and bubble controls.

## Interface
- REG_ADDR_W, 5, register address width
- FLUSH_DEPTH, 2, number of wrong-path slots squashed per taken branch (≥2)
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (≥1)
- CNT_W, 32, performance counter width
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- rs1_id, rs2_id  in  REG_ADDR_W  sources of the instruction in ID
- rs1_ex, rs2_ex  in  REG_ADDR_W  sources of the instruction in EX
- rd_ex, rd_ma, rd_wb  in  REG_ADDR_W  destinations in EX, MA and WB
- regwen_ex, regwen_ma, regwen_wb  in  1  register write enables per stage
- memread_ex  in  1  instruction in EX is a load
- pcsel_ex  in  1  taken branch or jump resolved in EX
- dmem_req  in  1  MA stage has a memory access
- dmem_ready  in  1  data memory completes this cycle
- fwd_sel_a, fwd_sel_b  out  2  00 = register file, 01 = MA ALU result, 10 = WB data
- stall_if, stall_id  out  1  hold PC and the IF/ID register
- bubble_ex  out  1  load a NOP into ID/EX
- flush_id  out  1  clear IF/ID
- stall_all  out  1  freeze every pipeline register
- state_o  out  2  current FSM state
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- **Forwarding** (combinational, per operand):
  - Select MA if regwen_ma, rd_ma≠0 and rd_ma==rs_ex.
  - Otherwise select WB under the same rule using regwen_wb and rd_wb.
  - Otherwise select the register file.
  - MA has priority over WB.
- **Load-use hazard**: memread_ex & regwen_ex & rd_ex≠0 & (rd_ex==rs1_id | rd_ex==rs2_id).
- **FSM states**: RUN=0, LD_STALL=1, FLUSH=2, MEM_WAIT=3.
- **RUN**, priority from highest to lowest:
  - dmem_req & !dmem_ready: stall_all=1, go to MEM_WAIT; pcsel_ex and load-use are ignored this cycle.
  - pcsel_ex: flush_id=1 and bubble_ex=1 this cycle. If FLUSH_DEPTH>2, go to FLUSH with counter=FLUSH_DEPTH-2. A load-use hazard in the same cycle is discarded because the instruction in ID is wrong-path.
  - load-use: stall_if=1, stall_id=1, bubble_ex=1. If LOAD_STALL_CYCLES>1, go to LD_STALL with counter=LOAD_STALL_CYCLES-1.
- **LD_STALL**:
  - Assert stall_if, stall_id and bubble_ex; decrement the counter.
  - At counter 1, return to RUN.
  - pcsel_ex aborts the stall and takes the RUN branch path.
  - A memory wait takes precedence, as in RUN.
- **FLUSH**:
  - Assert flush_id; decrement the counter; return to RUN at 1.
  - A new pcsel_ex reloads the counter.
- **MEM_WAIT**:
  - Hold stall_all=1 while !dmem_ready.
  - When dmem_ready, deassert stall_all in that same cycle and return to RUN. This is the completion cycle, in which the pipeline advances.
  - The FLUSH and LD_STALL counters are frozen during the wait. Pending work is re-detected from the held stage contents.
- While stall_all=1, the other control outputs read 0; forwarding selects stay valid.
- Counters wrap modulo 2^CNT_W.

## Timing
- Forwarding, stall, flush and bubble outputs are combinational from the inputs and the registered state, with zero-cycle latency.
- State and counters update on the rising edge of clk.
- Reset (asynchronous, any time): state=RUN and all counters cleared.
- While reset_n=0, every control output reads 0: fwd_sel_a/b=00, stall_if, stall_id, bubble_ex, flush_id and stall_all=0.
- Reset asserted mid-stall or mid-flush abandons the operation immediately.
- Load-use costs LOAD_STALL_CYCLES cycles; a taken branch costs FLUSH_DEPTH slots.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments each cycle in which stall_if or stall_all is 1.
  - flush_cnt increments once per accepted pcsel_ex.
- Undefined: counter logic is omitted and both counter ports are tied to 0. The port list is unchanged.

## Structure
- Shared package hazard_pkg holds:
  - the state enum (RUN, LD_STALL, FLUSH, MEM_WAIT);
  - the FWD_RF, FWD_MA and FWD_WB select constants.
- Sub-module fwd_sel_logic is instantiated twice, once per EX source operand.

## Test plan
- addi x5 in MA, add rs1=x5 in EX, same x5 also in WB → fwd_sel_a=01; with rd=x0 → fwd_sel_a=00.
- lw x6 in EX, add rs2=x6 in ID, LOAD_STALL_CYCLES=1 → stall_if=stall_id=bubble_ex=1 for exactly 1 cycle, then fwd_sel_b=10 on the retry.
- pcsel_ex=1 coincident with a load-use hazard, FLUSH_DEPTH=3 → flush_id for 2 cycles, bubble_ex for 1 cycle, no stall, flush_cnt+1.
- dmem_req=1 with dmem_ready low for 3 cycles → stall_all=1 for 3 cycles, 0 in the ready cycle, state returns to 0; stall_cnt+3.
- reset_n dropped in LD_STALL with LOAD_STALL_CYCLES=3 → all outputs 0 immediately; state_o=0 and counters 0 after release.
- Build without HAZARD_PERF_CNT_EN → stall_cnt=flush_cnt=0 through all of the above.
